// File: rtl/warp_sched_pkg.sv
// Shared types and defaults for the warp issue scheduler.
// Holds the default geometry, FSM encoding and the warp-id one-hot decode.
package warp_sched_pkg;

   localparam int DEF_NUM_WARPS = 4;
   localparam int DEF_PC_WIDTH  = 8;
   localparam int DEF_WID_WIDTH = $clog2(DEF_NUM_WARPS);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   function automatic logic [DEF_NUM_WARPS-1:0] wid_onehot(
      input logic [DEF_WID_WIDTH-1:0] id,
      input logic                     en
   );
      logic [DEF_NUM_WARPS-1:0] oh;
      oh     = '0;
      oh[id] = en;
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter over the per-warp eligible flags.
// Highest priority is at ptr, searching upward with natural wrap.
module rr_arbiter
   import warp_sched_pkg::*;
#(
   parameter int NUM_WARPS = DEF_NUM_WARPS,
   parameter int WID_WIDTH = $clog2(NUM_WARPS)
) (
   input  logic [NUM_WARPS-1:0] req,
   input  logic [WID_WIDTH-1:0] ptr,
   output logic [NUM_WARPS-1:0] grant,
   output logic [WID_WIDTH-1:0] grant_id,
   output logic                 any_grant
);

   logic [WID_WIDTH-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_id  = '0;
      any_grant = 1'b0;
      idx       = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         idx = ptr + WID_WIDTH'(i);
         if (!any_grant && req[idx]) begin
            any_grant = 1'b1;
            grant_id  = idx;
         end
      end
      grant[grant_id] = any_grant;
   end

endmodule

// File: rtl/warp_scheduler.sv
// Per-cycle warp issue scheduler with a registered valid/ready issue slot.
// Define WARP_SCHED_GTO_EN for greedy-then-oldest selection.
module warp_scheduler
   import warp_sched_pkg::*;
#(
   parameter int NUM_WARPS = DEF_NUM_WARPS,
   parameter int PC_WIDTH  = DEF_PC_WIDTH,
   parameter int WID_WIDTH = $clog2(NUM_WARPS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sched_en,
   input  logic [NUM_WARPS-1:0]          warp_active,
   input  logic [NUM_WARPS-1:0]          warp_ready,
   input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
   input  logic                          issue_ready,
   output logic                          issue_valid,
   output logic [WID_WIDTH-1:0]          issue_warp_id,
   output logic [PC_WIDTH-1:0]           issue_pc,
   output logic [NUM_WARPS-1:0]          pc_update_en
);

   state_t               state;
   state_t               state_nxt;
   logic                 fire;
   logic                 load;
   logic                 greedy;
   logic [NUM_WARPS-1:0] held;
   logic [NUM_WARPS-1:0] eligible;
   logic [NUM_WARPS-1:0] arb_grant;
   logic [NUM_WARPS-1:0] sel_oh;
   logic [WID_WIDTH-1:0] arb_id;
   logic [WID_WIDTH-1:0] sel_id;
   logic [WID_WIDTH-1:0] rr_ptr;
   logic [PC_WIDTH-1:0]  sel_pc;
   logic                 arb_any;

   assign issue_valid  = (state == FULL);
   assign fire         = issue_valid & issue_ready;
   assign held         = wid_onehot(issue_warp_id, issue_valid);
   assign pc_update_en = wid_onehot(issue_warp_id, fire);

   // Masking the firing warp keeps us from capturing the PC it is replacing.
   assign eligible = {NUM_WARPS{sched_en}} & warp_active & warp_ready
                   & ~held & ~pc_update_en;

   rr_arbiter #(
      .NUM_WARPS (NUM_WARPS),
      .WID_WIDTH (WID_WIDTH)
   ) u_arb (
      .req       (eligible),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_id  (arb_id),
      .any_grant (arb_any)
   );

`ifdef WARP_SCHED_GTO_EN
   logic [WID_WIDTH-1:0] last_id;

   assign greedy = eligible[last_id];
   assign sel_id = greedy ? last_id : arb_id;
   assign sel_oh = greedy ? wid_onehot(last_id, 1'b1) : arb_grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_id <= '0;
      end else if (load) begin
         last_id <= sel_id;
      end
   end
`else
   assign greedy = 1'b0;
   assign sel_id = arb_id;
   assign sel_oh = arb_grant;
`endif

   always_comb begin
      sel_pc = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (sel_oh[i]) begin
            sel_pc = sel_pc | warp_pc[i*PC_WIDTH +: PC_WIDTH];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      unique case (state)
         EMPTY: begin
            if (arb_any) begin
               load      = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (fire) begin
               load      = arb_any;
               state_nxt = arb_any ? FULL : EMPTY;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= EMPTY;
         issue_warp_id <= '0;
         issue_pc      <= '0;
         rr_ptr        <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            issue_warp_id <= sel_id;
            issue_pc      <= sel_pc;
         end
         if (load && !greedy) begin
            rr_ptr <= arb_id + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed scoreboard bench for warp_scheduler.
// Drives a small warp-state model whose PCs advance by 2 on pc_update_en.
module tb_warp_scheduler;

   logic       clk;
   logic       reset;
   logic       sched_en;
   logic [3:0] warp_active;
   logic [3:0] warp_ready;
   logic [31:0] warp_pc;
   logic       issue_ready;
   logic       issue_valid;
   logic [1:0] issue_warp_id;
   logic [7:0] issue_pc;
   logic [3:0] pc_update_en;

   logic [7:0] pcs [4];

   typedef struct {
      logic [1:0] id;
      logic [7:0] pc;
   } exp_t;

   exp_t sbq [$];
   int   errors = 0;
   int   checks = 0;

   assign warp_pc = {pcs[3], pcs[2], pcs[1], pcs[0]};

   warp_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .sched_en      (sched_en),
      .warp_active   (warp_active),
      .warp_ready    (warp_ready),
      .warp_pc       (warp_pc),
      .issue_ready   (issue_ready),
      .issue_valid   (issue_valid),
      .issue_warp_id (issue_warp_id),
      .issue_pc      (issue_pc),
      .pc_update_en  (pc_update_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] id, input logic [7:0] pc);
      exp_t e;
      e.id = id;
      e.pc = pc;
      sbq.push_back(e);
   endtask

   // Called at a handshake: compares the slot against the oldest expectation.
   task automatic chk_issue(input string tag);
      exp_t e;
      logic [3:0] oh;
      chk({tag, "_valid"}, {31'd0, issue_valid}, 32'd1);
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      end else begin
         e  = sbq.pop_front();
         oh = 4'b0001 << e.id;
         chk({tag, "_id"},  {30'd0, issue_warp_id}, {30'd0, e.id});
         chk({tag, "_pc"},  {24'd0, issue_pc},      {24'd0, e.pc});
         chk({tag, "_upd"}, {28'd0, pc_update_en},  {28'd0, oh});
      end
   endtask

   // Advance one cycle; the warp-state model bumps PCs on the edge.
   task automatic tick();
      logic [3:0] upd;
      upd = pc_update_en;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (upd[k]) pcs[k] = pcs[k] + 8'd2;
      end
   endtask

   initial begin
      reset       = 1'b1;
      sched_en    = 1'b0;
      warp_active = 4'b0000;
      warp_ready  = 4'b0000;
      issue_ready = 1'b0;
      pcs[0] = 8'h10;
      pcs[1] = 8'h20;
      pcs[2] = 8'h30;
      pcs[3] = 8'h40;
      tick();
      tick();
      #1;
      chk("rst_valid", {31'd0, issue_valid}, 32'd0);
      chk("rst_id", {30'd0, issue_warp_id}, 32'd0);
      chk("rst_pc", {24'd0, issue_pc}, 32'd0);
      chk("rst_upd", {28'd0, pc_update_en}, 32'd0);
      reset = 1'b0;

      // Rotation
      sched_en    = 1'b1;
      warp_active = 4'b1111;
      warp_ready  = 4'b1111;
      issue_ready = 1'b1;
      push(2'd0, 8'h10);
      push(2'd1, 8'h20);
      push(2'd2, 8'h30);
      push(2'd3, 8'h40);
      push(2'd0, 8'h12);
      push(2'd1, 8'h22);
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_issue("rot");
         tick();
      end
      warp_ready = 4'b0000;
      #1;
      chk_issue("rot_last");
      tick();
      chk("rot_drain", {31'd0, issue_valid}, 32'd0);

      // Backpressure on warp 2
      warp_ready  = 4'b0100;
      issue_ready = 1'b0;
      push(2'd2, 8'h32);
      tick();
      for (int j = 0; j < 5; j++) begin
         pcs[2] = 8'h50 + 8'(j);
         #1;
         chk("bp_valid", {31'd0, issue_valid}, 32'd1);
         chk("bp_id", {30'd0, issue_warp_id}, 32'd2);
         chk("bp_pc", {24'd0, issue_pc}, 32'h32);
         chk("bp_upd", {28'd0, pc_update_en}, 32'd0);
         tick();
      end
      warp_ready  = 4'b0000;
      issue_ready = 1'b1;
      #1;
      chk_issue("bp_fire");
      tick();
      chk("bp_after_valid", {31'd0, issue_valid}, 32'd0);
      chk("bp_after_upd", {28'd0, pc_update_en}, 32'd0);

      // Single ready warp issues every other cycle
      warp_ready = 4'b0010;
      push(2'd1, 8'h24);
      push(2'd1, 8'h26);
      tick();
      #1;
      chk_issue("single0");
      tick();
      chk("single_gap0", {31'd0, issue_valid}, 32'd0);
      tick();
      chk_issue("single1");
      tick();
      chk("single_gap1", {31'd0, issue_valid}, 32'd0);
      warp_ready = 4'b0000;
      tick();

      // sched_en drop while FULL
      warp_ready  = 4'b0001;
      issue_ready = 1'b0;
      push(2'd0, 8'h14);
      tick();
      sched_en = 1'b0;
      tick();
      chk("sen_hold", {31'd0, issue_valid}, 32'd1);
      issue_ready = 1'b1;
      #1;
      chk_issue("sen_fire");
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("sen_idle", {31'd0, issue_valid}, 32'd0);
      end
      sched_en    = 1'b1;
      issue_ready = 1'b0;
      tick();
      chk("sen_resume", {31'd0, issue_valid}, 32'd1);
      chk("sen_resume_pc", {24'd0, issue_pc}, 32'h16);

      // Reset while FULL with issue_ready low
      sbq.delete();
      reset = 1'b1;
      #1;
      chk("mrst_valid", {31'd0, issue_valid}, 32'd0);
      chk("mrst_id", {30'd0, issue_warp_id}, 32'd0);
      chk("mrst_pc", {24'd0, issue_pc}, 32'd0);
      issue_ready = 1'b1;
      #1;
      chk("mrst_upd", {28'd0, pc_update_en}, 32'd0);
      warp_ready = 4'b0000;
      tick();
      reset = 1'b0;
      tick();
      chk("mrst_rel_upd", {28'd0, pc_update_en}, 32'd0);
      chk("mrst_rel_valid", {31'd0, issue_valid}, 32'd0);

      // Pointer must restart from 0 after reset
      warp_ready  = 4'b1001;
      issue_ready = 1'b0;
      push(2'd0, 8'h16);
      push(2'd3, 8'h42);
      tick();
      issue_ready = 1'b1;
      warp_ready  = 4'b1000;
      #1;
      chk_issue("ptr0");
      tick();
      warp_ready = 4'b0000;
      #1;
      chk_issue("ptr3");
      tick();
      chk("ptr_empty", {31'd0, issue_valid}, 32'd0);

      // Greedy vs round-robin with warp 3 last loaded, pointer at 0
      warp_ready  = 4'b1001;
      issue_ready = 1'b0;
      tick();
`ifdef WARP_SCHED_GTO_EN
      chk("gto_id", {30'd0, issue_warp_id}, 32'd3);
      chk("gto_pc", {24'd0, issue_pc}, 32'h44);
`else
      chk("rr_id", {30'd0, issue_warp_id}, 32'd0);
      chk("rr_pc", {24'd0, issue_pc}, 32'h18);
`endif
      chk("sb_empty", sbq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

- Per-cycle issue scheduler for the compute unit.
- Picks one eligible warp from the per-warp ready flags (one flag per warp-state block) and presents that warp's PC to the fetch/issue stage through a registered valid/ready slice.
- Pulses the chosen warp's `pc_update_en` on the handshake so that warp's PC advances.
- Sits between the warp-state array and instruction fetch.

## Interface
- `NUM_WARPS`, 4, number of warps arbitrated (power of two, ≥2)
- `PC_WIDTH`, 8, PC width per warp
- `WID_WIDTH`, $clog2(NUM_WARPS), warp-id width
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `sched_en` in 1: 0 = no new selections; a held issue still completes.
- `warp_active` in NUM_WARPS: per-warp launched/not-finished mask.
- `warp_ready` in NUM_WARPS: per-warp future-ready flags.
- `warp_pc` in NUM_WARPS*PC_WIDTH: flattened PCs, warp i at [i*PC_WIDTH +: PC_WIDTH].
- `issue_ready` in 1: fetch stage accepts.
- `issue_valid` out 1: issue slot holds a warp.
- `issue_warp_id` out WID_WIDTH: held warp id.
- `issue_pc` out PC_WIDTH: held warp's PC, captured at selection.
- `pc_update_en` out NUM_WARPS: one-hot; bit k = issue_valid & issue_ready & (issue_warp_id==k).

## Operation
- Eligible[i] = sched_en & warp_active[i] & warp_ready[i] & ~held[i] & ~firing[i].
  - held[i] = issue_valid & issue_warp_id==i.
  - firing[i] = pc_update_en[i].
  - This rule prevents sampling a stale PC in the cycle it is being updated.
- FSM, 2 states:
  - EMPTY: no issue held. Any eligible warp → load slot, go to FULL.
  - FULL: issue held.
    - Fire (valid & ready) with an eligible warp present → reload the slot in the same cycle (back-to-back), stay FULL.
    - Fire with no eligible warp → EMPTY.
    - No fire → hold; issue_warp_id and issue_pc stay stable.
- Arbitration: round-robin. Pointer `rr_ptr` (WID_WIDTH) marks the highest-priority warp.
  - Search rr_ptr, rr_ptr+1, … mod NUM_WARPS.
  - On load of warp k: rr_ptr ← (k+1) mod NUM_WARPS (natural wrap).
  - Pointer unchanged when nothing loads.
- Load captures warp_pc[k] into issue_pc and k into issue_warp_id.
- sched_en falling while FULL: slot drains normally on its handshake, then stays EMPTY.
- warp_active[k] dropping while warp k is held: the issue still completes; no cancel.

## Timing
- Reset values: issue_valid=0, issue_warp_id=0, issue_pc=0, pc_update_en=0, state EMPTY, rr_ptr=0.
- Latency: eligibility at edge t → issue_valid high after edge t (one cycle).
- pc_update_en is combinational from registered state and issue_ready.
  - Asserted exactly in the handshake cycle.
  - Warp PC advances at the same edge that completes the handshake.
- Throughput: one issue per cycle with issue_ready held high and ≥2 warps ready.
- A single ready warp issues at most every other cycle (firing mask).
- Handshake rules:
  - issue_valid never drops without a handshake, except on reset.
  - issue_warp_id and issue_pc are stable while valid & ~ready.
- Reset mid-operation: the held issue is discarded; no pc_update_en pulse.

## Configuration
- `WARP_SCHED_GTO_EN` defined: greedy-then-oldest.
  - If the last-loaded warp (`last_id`, reset 0) is eligible, it is selected again.
  - Otherwise round-robin from rr_ptr; rr_ptr updates only on non-greedy loads.
  - last_id updates on every load.
- Undefined: pure round-robin; last_id logic absent.

## Structure
- Shared package `warp_sched_pkg`:
  - NUM_WARPS, PC_WIDTH, WID_WIDTH defaults.
  - State encoding (EMPTY=0, FULL=1).
  - Function for warp-id → one-hot decode.
- Sub-module `rr_arbiter`:
  - Parameterized NUM_WARPS.
  - Ports: req vector, pointer → grant one-hot, grant id, any_grant.
  - Purely combinational; the pointer register lives in warp_scheduler.

## Test plan
- **Reset:** assert reset mid-FULL with issue_ready=0 → all outputs 0 at once; no pc_update_en pulse after release.
- **Rotation:** all 4 warps active+ready, issue_ready=1, PCs 0x10/0x20/0x30/0x40 → issue_warp_id sequence 0,1,2,3,0 with matching PCs; pc_update_en 0001,0010,0100,1000.
- **Backpressure:** warp 2 held, issue_ready=0 for 5 cycles while warp 2's PC input changes → issue_pc stays at its captured value; pc_update_en=0; then one pulse 0100.
- **Single warp:** only warp 1 ready, issue_ready=1 → issue_valid pattern 1,0,1,0; each pulse 0010; issue_pc = previous PC+2.
- **sched_en drop:** sched_en=0 while FULL → the held issue completes once, then issue_valid=0 until sched_en=1.
- **GTO:** with `WARP_SCHED_GTO_EN` defined, warps 0 and 3 ready, warp 3 last loaded and eligible → 3 is selected whenever eligible; 0 is selected only in warp 3's masked cycles.
